alu_cmd_driver: RTL and testbench
=================================

# alu_cmd_driver

Command-side driver for the 8-bit ALU: accepts operation commands from an upstream requester through a valid/ready port and buffers them in a small FIFO. Issues them one at a time onto the ALU input interface (valid, lhs, rhs, function) and waits for the ALU's result-valid. Returns each result, tagged with its function code, to a downstream consumer through a valid/ready port. It is the initiator that sits in front of the ALU, which is the responder.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT, 15, max WAIT cycles before abandoning an op (only with timeout compiled in); ≥1
- in_clock  input  1  sole clock, all logic on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_cmd_valid  input  1  command present
- out_cmd_ready  output  1  FIFO can accept; equals !full
- in_cmd_lhs  input  8  left operand
- in_cmd_rhs  input  8  right operand
- in_cmd_function  input  3  ALU function code
- out_alu_valid  output  1  issue strobe to ALU in_valid
- out_alu_lhs  output  8  to ALU in_lhs
- out_alu_rhs  output  8  to ALU in_rhs
- out_alu_function  output  3  to ALU in_function
- in_alu_valid  input  1  ALU out_valid
- in_alu_result  input  8  ALU out_result
- out_rsp_valid  output  1  response present
- in_rsp_ready  input  1  consumer accepts
- out_rsp_result  output  8  captured result
- out_rsp_function  output  3  function code of the op that produced it
- out_rsp_timeout  output  1  response is a timeout, result forced 0

## Operation
- FIFO: push on in_cmd_valid && out_cmd_ready; entry = {lhs, rhs, function}. No bypass: a pushed entry is visible to the FSM the cycle after the push. Occupancy counter of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty -> ISSUE.
- ISSUE: exactly one cycle. out_alu_valid=1 and out_alu_* = FIFO head. Pop at end of cycle; latch function. -> WAIT, clear timeout counter.
- WAIT: on in_alu_valid, capture in_alu_result into out_rsp_result and set timeout=0 -> RESP. Otherwise increment counter.
- RESP: out_rsp_valid=1 and outputs held stable until in_rsp_ready. On the handshake -> IDLE.
- Only one op is outstanding. in_alu_valid outside WAIT is ignored and nothing is captured.
- out_alu_lhs/rhs/function are 0 when out_alu_valid=0.
- Push and pop in the same cycle: occupancy unchanged. A push is impossible while full because ready is low.
- Reset (including mid-op): FSM -> IDLE, FIFO emptied, in-flight op discarded. Outputs: out_cmd_ready=1; out_alu_valid=0; out_alu_* = 0; out_rsp_valid=0; out_rsp_result=0; out_rsp_function=0; out_rsp_timeout=0. An in_alu_valid arriving after reset is ignored.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths except out_cmd_ready, which comes from the occupancy register.
- Single-cycle ALU, empty FIFO, consumer ready: command accepted at edge e0, out_alu_valid high after e1, out_rsp_valid high after e3. RESP is left at e4.
- Back-to-back throughput: one op per 4 cycles when in_rsp_ready is held high.
- Back-pressure on the response stalls issue. The FIFO keeps accepting commands until full.

## Configuration
- ALU_CMD_DRIVER_TIMEOUT_EN defined: WAIT counts cycles. When the counter reaches TIMEOUT without in_alu_valid, the FSM -> RESP with out_rsp_result=0 and out_rsp_timeout=1. in_alu_valid in the same cycle as the counter reaching TIMEOUT wins as a normal response.
- Not defined: no counter is built. WAIT persists indefinitely and out_rsp_timeout is tied 0.

## Test plan
- Single op: lhs=19, rhs=7, func=000, 1-cycle ALU model returning 26, rsp_ready=1 -> out_alu_valid pulses once with 19/7/000, out_rsp_valid after e3 with result=26, function=000, timeout=0.
- Burst of 5 commands, rsp_ready=0, DEPTH=4: 4 accepted, out_cmd_ready=0 on the 5th. The first op parks in RESP. Releasing ready drains results in order, func 000..100.
- Response back-pressure: hold in_rsp_ready=0 for 6 cycles -> out_rsp_valid, result, and function stable throughout, with no second out_alu_valid.
- Timeout (macro defined, TIMEOUT=15): ALU model never responds -> RESP after 15 WAIT cycles with result=0, timeout=1; a late in_alu_valid is then ignored. Without the macro, the block stays in WAIT.
- Stray in_alu_valid pulsed in IDLE with result 0xAA -> no response generated; the next real op returns its own result.
- Reset asserted in WAIT with 2 entries queued -> next cycle all outputs at reset values and out_cmd_ready=1; an ALU response one cycle later produces no output.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// Command-side driver for the 8-bit ALU: FIFO-buffered commands issued one at a time, results returned with their function code.
// Optional WAIT timeout is compiled in with `define ALU_CMD_DRIVER_TIMEOUT_EN.
module alu_cmd_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_cmd_valid,
  output logic       out_cmd_ready,
  input  logic [7:0] in_cmd_lhs,
  input  logic [7:0] in_cmd_rhs,
  input  logic [2:0] in_cmd_function,
  output logic       out_alu_valid,
  output logic [7:0] out_alu_lhs,
  output logic [7:0] out_alu_rhs,
  output logic [2:0] out_alu_function,
  input  logic       in_alu_valid,
  input  logic [7:0] in_alu_result,
  output logic       out_rsp_valid,
  input  logic       in_rsp_ready,
  output logic [7:0] out_rsp_result,
  output logic [2:0] out_rsp_function,
  output logic       out_rsp_timeout,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a valid source holds its payload stable until that edge, ready may be
  // driven freely and never depends on valid.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic [2:0] func;
  } cmd_t;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("alu_cmd_driver: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  state_t        state_q;
  state_t        state_d;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          to_hit;

  // ---------------------------------------------------------------- command FIFO
  assign out_cmd_ready = (count != CW'(DEPTH));
  assign fifo_empty    = (count == '0);
  assign push          = in_cmd_valid && out_cmd_ready;
  assign head          = mem[rd_ptr];

  always_ff @(posedge in_clock) begin
    if (push) begin
      mem[wr_ptr] <= '{lhs: in_cmd_lhs, rhs: in_cmd_rhs, func: in_cmd_function};
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- WAIT timeout
`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;
  logic          rsp_timeout_q;

  // Fires on the WAIT cycle whose increment would bring the count to TIMEOUT.
  assign to_hit          = (state_q == WAIT) && (to_cnt == TW'(TIMEOUT - 1));
  assign out_rsp_timeout = rsp_timeout_q;

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      to_cnt        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        to_cnt <= '0;
      end else if (state_q == WAIT && !in_alu_valid && !to_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state_q == WAIT) begin
        if (in_alu_valid) rsp_timeout_q <= 1'b0;
        else if (to_hit)  rsp_timeout_q <= 1'b1;
      end
    end
  end
`else
  assign to_hit          = 1'b0;
  assign out_rsp_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge in_clock) begin
    if (in_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    pop              = 1'b0;
    out_alu_valid    = 1'b0;
    out_alu_lhs      = 8'd0;
    out_alu_rhs      = 8'd0;
    out_alu_function = 3'd0;
    out_rsp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end
      ISSUE: begin
        out_alu_valid    = 1'b1;
        out_alu_lhs      = head.lhs;
        out_alu_rhs      = head.rhs;
        out_alu_function = head.func;
        pop              = 1'b1;
        state_d          = WAIT;
      end
      WAIT: begin
        if (in_alu_valid || to_hit) state_d = RESP;
      end
      RESP: begin
        out_rsp_valid = 1'b1;
        if (in_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------- response capture
  // The function is latched at issue; result only moves while in WAIT, so both
  // stay frozen for the whole RESP stall.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      out_rsp_result   <= 8'd0;
      out_rsp_function <= 3'd0;
    end else begin
      if (state_q == ISSUE) out_rsp_function <= head.func;
      if (state_q == WAIT) begin
        if (in_alu_valid) out_rsp_result <= in_alu_result;
        else if (to_hit)  out_rsp_result <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: directed vectors, a queue-based reference model checked every
// cycle, and hand-computed literal checks. Timeout checks follow ALU_CMD_DRIVER_TIMEOUT_EN.
module tb_alu_cmd_driver;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  // ---------------------------------------------------------------- clock / reset
  logic in_clock = 1'b0;
  logic in_reset;
  always #5 in_clock = ~in_clock;

  logic       in_cmd_valid;
  logic       out_cmd_ready;
  logic [7:0] in_cmd_lhs;
  logic [7:0] in_cmd_rhs;
  logic [2:0] in_cmd_function;
  logic       out_alu_valid;
  logic [7:0] out_alu_lhs;
  logic [7:0] out_alu_rhs;
  logic [2:0] out_alu_function;
  logic       in_alu_valid;
  logic [7:0] in_alu_result;
  logic       out_rsp_valid;
  logic       in_rsp_ready;
  logic [7:0] out_rsp_result;
  logic [2:0] out_rsp_function;
  logic       out_rsp_timeout;
  logic [1:0] dbg_state;

  // ALU input is the OR of the responding ALU model and directed stray pulses.
  logic       alu_en;
  logic       model_v;
  logic [7:0] model_r;
  logic       stray_v;
  logic [7:0] stray_r;
  assign in_alu_valid  = model_v | stray_v;
  assign in_alu_result = model_v ? model_r : stray_r;

  alu_cmd_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .in_clock         (in_clock),
    .in_reset         (in_reset),
    .in_cmd_valid     (in_cmd_valid),
    .out_cmd_ready    (out_cmd_ready),
    .in_cmd_lhs       (in_cmd_lhs),
    .in_cmd_rhs       (in_cmd_rhs),
    .in_cmd_function  (in_cmd_function),
    .out_alu_valid    (out_alu_valid),
    .out_alu_lhs      (out_alu_lhs),
    .out_alu_rhs      (out_alu_rhs),
    .out_alu_function (out_alu_function),
    .in_alu_valid     (in_alu_valid),
    .in_alu_result    (in_alu_result),
    .out_rsp_valid    (out_rsp_valid),
    .in_rsp_ready     (in_rsp_ready),
    .out_rsp_result   (out_rsp_result),
    .out_rsp_function (out_rsp_function),
    .out_rsp_timeout  (out_rsp_timeout),
    .dbg_state        (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] f);
    case (f)
      3'd0:    alu_fn = a + b;
      3'd1:    alu_fn = a - b;
      3'd2:    alu_fn = a & b;
      3'd3:    alu_fn = a | b;
      3'd4:    alu_fn = a ^ b;
      3'd5:    alu_fn = ~a;
      3'd6:    alu_fn = a << 1;
      default: alu_fn = a >> 1;
    endcase
  endfunction

  // ---------------------------------------------------------------- ALU responder (1-cycle)
  logic [7:0] alu_tmp;
  initial begin
    model_v = 1'b0;
    model_r = 8'd0;
    forever begin
      @(negedge in_clock);
      if (out_alu_valid && alu_en) begin
        alu_tmp = alu_fn(out_alu_lhs, out_alu_rhs, out_alu_function);
        @(posedge in_clock); #1;
        model_v = 1'b1;
        model_r = alu_tmp;
        @(posedge in_clock); #1;
        model_v = 1'b0;
        model_r = 8'd0;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [18:0] cmd_q[$];   // accepted commands {lhs, rhs, func}
  logic [11:0] exp_q[$];   // expected responses {timeout, result, func}
  logic        busy;
  logic        prev_rst;
  logic [18:0] cur_cmd;

  initial begin
    busy     = 1'b0;
    prev_rst = 1'b0;
    forever begin
      @(negedge in_clock);
      if (prev_rst)
        check("reset_values",
              {out_cmd_ready, out_alu_valid, out_alu_lhs, out_alu_rhs, out_alu_function,
               out_rsp_valid, out_rsp_result, out_rsp_function, out_rsp_timeout},
              {1'b1, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 8'd0, 3'd0, 1'b0});
      prev_rst = in_reset;
      if (in_reset) begin
        cmd_q.delete();
        exp_q.delete();
        busy = 1'b0;
      end else begin
        check("cmd_ready", out_cmd_ready, cmd_q.size() < DEPTH);
        if (in_cmd_valid && out_cmd_ready)
          cmd_q.push_back({in_cmd_lhs, in_cmd_rhs, in_cmd_function});
        if (out_alu_valid) begin
          check("issue_while_busy", busy, 1'b0);
          if (cmd_q.size() == 0) begin
            check("issue_without_cmd", out_alu_valid, 1'b0);
          end else begin
            cur_cmd = cmd_q.pop_front();
            check("alu_issue", {out_alu_lhs, out_alu_rhs, out_alu_function}, cur_cmd);
            busy = 1'b1;
            if (alu_en)
              exp_q.push_back({1'b0, alu_fn(cur_cmd[18:11], cur_cmd[10:3], cur_cmd[2:0]),
                               cur_cmd[2:0]});
`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
            else
              exp_q.push_back({1'b1, 8'd0, cur_cmd[2:0]});
`endif
          end
        end else begin
          check("alu_idle_zero", {out_alu_lhs, out_alu_rhs, out_alu_function}, 19'd0);
        end
        if (out_rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", out_rsp_valid, 1'b0);
          end else begin
            check("rsp", {out_rsp_timeout, out_rsp_result, out_rsp_function}, exp_q[0]);
            if (in_rsp_ready) begin
              void'(exp_q.pop_front());
              busy = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic cycle(input int n);
    repeat (n) @(posedge in_clock);
    #1;
  endtask

  task automatic push1(input logic [7:0] l, input logic [7:0] r, input logic [2:0] f,
                       output bit acc);
    in_cmd_valid    = 1'b1;
    in_cmd_lhs      = l;
    in_cmd_rhs      = r;
    in_cmd_function = f;
    acc             = out_cmd_ready;
    cycle(1);
    in_cmd_valid    = 1'b0;
    in_cmd_lhs      = 8'd0;
    in_cmd_rhs      = 8'd0;
    in_cmd_function = 3'd0;
  endtask

  task automatic wait_rsp(input int limit, output int waited);
    waited = 0;
    while (!out_rsp_valid && waited < limit) begin
      cycle(1);
      waited++;
    end
    check("rsp_arrives", out_rsp_valid, 1'b1);
  endtask

  task automatic stray_pulse(input logic [7:0] v);
    stray_v = 1'b1;
    stray_r = v;
    cycle(1);
    stray_v = 1'b0;
    stray_r = 8'd0;
  endtask

  // ---------------------------------------------------------------- directed sequence
  bit acc;
  int w;

  initial begin
    in_reset        = 1'b1;
    in_cmd_valid    = 1'b0;
    in_cmd_lhs      = 8'd0;
    in_cmd_rhs      = 8'd0;
    in_cmd_function = 3'd0;
    in_rsp_ready    = 1'b1;
    alu_en          = 1'b1;
    stray_v         = 1'b0;
    stray_r         = 8'd0;
    cycle(3);
    in_reset = 1'b0;

    // single op: push at e0, issue after e1, response after e3, leave at e4
    push1(8'd19, 8'd7, 3'b000, acc);
    check("single_accept", acc, 1'b1);
    check("single_no_bypass", out_alu_valid, 1'b0);
    cycle(1);
    check("single_issue", {out_alu_valid, out_alu_lhs, out_alu_rhs, out_alu_function},
          {1'b1, 8'd19, 8'd7, 3'b000});
    cycle(1);
    check("single_wait", {out_alu_valid, out_rsp_valid}, 2'b00);
    cycle(1);
    check("single_rsp", {out_rsp_valid, out_rsp_result, out_rsp_function, out_rsp_timeout},
          {1'b1, 8'd26, 3'b000, 1'b0});
    cycle(1);
    check("single_rsp_done", out_rsp_valid, 1'b0);
    cycle(2);

    // park one op in RESP, hold back-pressure, then burst 5 commands into the FIFO
    in_rsp_ready = 1'b0;
    push1(8'h40, 8'h02, 3'd0, acc);
    wait_rsp(10, w);
    for (int i = 0; i < 6; i++) begin
      check("bp_hold", {out_rsp_valid, out_rsp_result, out_rsp_function, out_alu_valid},
            {1'b1, 8'h42, 3'd0, 1'b0});
      cycle(1);
    end
    for (int i = 1; i <= 5; i++) begin
      push1(8'(16 * i), 8'(i), 3'(i), acc);
      check("burst_accept", acc, i <= 4);
    end
    check("burst_full", out_cmd_ready, 1'b0);
    in_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(20, w);
      check("drain_order", out_rsp_function, i);
      if (i > 0) check("drain_spacing", w, 3);
      cycle(1);
    end
    cycle(2);

    // stray ALU valid while idle produces nothing; next op returns its own result
    stray_pulse(8'hAA);
    for (int i = 0; i < 4; i++) begin
      check("stray_ignored", out_rsp_valid, 1'b0);
      cycle(1);
    end
    push1(8'd5, 8'd3, 3'd1, acc);
    wait_rsp(10, w);
    check("after_stray", {out_rsp_result, out_rsp_function, out_rsp_timeout},
          {8'd2, 3'd1, 1'b0});
    cycle(1);

    // ALU never answers
    alu_en       = 1'b0;
    in_rsp_ready = 1'b0;
    push1(8'd9, 8'd9, 3'd2, acc);
`ifdef ALU_CMD_DRIVER_TIMEOUT_EN
    wait_rsp(40, w);
    check("timeout_latency", w, 17);
    check("timeout_rsp", {out_rsp_result, out_rsp_function, out_rsp_timeout},
          {8'd0, 3'd2, 1'b1});
    stray_pulse(8'hAA);
    check("timeout_late_valid", {out_rsp_valid, out_rsp_result, out_rsp_timeout},
          {1'b1, 8'd0, 1'b1});
    in_rsp_ready = 1'b1;
    cycle(1);
    check("timeout_rsp_done", out_rsp_valid, 1'b0);
`else
    cycle(30);
    check("no_timeout_stays_wait", {out_rsp_valid, out_rsp_timeout, dbg_state},
          {1'b0, 1'b0, 2'd2});
    in_reset = 1'b1;
    cycle(1);
    in_reset = 1'b0;
`endif
    in_rsp_ready = 1'b1;
    cycle(2);

    // reset while waiting with two entries queued
    push1(8'd11, 8'd1, 3'd3, acc);
    push1(8'd12, 8'd2, 3'd4, acc);
    push1(8'd13, 8'd3, 3'd5, acc);
    check("pre_reset_wait", {out_alu_valid, out_rsp_valid, out_cmd_ready}, 3'b001);
    in_reset = 1'b1;
    cycle(1);
    in_reset = 1'b0;
    check("mid_op_reset",
          {out_cmd_ready, out_alu_valid, out_alu_lhs, out_alu_rhs, out_alu_function,
           out_rsp_valid, out_rsp_result, out_rsp_function, out_rsp_timeout},
          {1'b1, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 8'd0, 3'd0, 1'b0});
    stray_pulse(8'h5C);
    for (int i = 0; i < 6; i++) begin
      check("post_reset_quiet", {out_alu_valid, out_rsp_valid}, 2'b00);
      cycle(1);
    end

    alu_en = 1'b1;
    cycle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
